// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S receive monitor: FSM encoding, word-select
// polarity and the default channel width.
package i2s_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAD   = 2'd2
    } rx_state_e;

    localparam logic LRCK_LEFT  = 1'b0;
    localparam int   DEF_DATA_W = 16;

endpackage

// File: rtl/i2s_rx_fifo.sv
// First-word-fall-through frame FIFO with wrap-bit pointers; a push into a
// full FIFO is refused (drop_o) unless the head is popped in the same cycle.
module i2s_rx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] rdata_o,
    output logic             drop_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             full, pop, push_ok;

    assign valid_o = (wr_ptr_q != rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop     = valid_o && ready_i;
    assign push_ok = push_i && (!full || pop);
    assign drop_o  = push_i && full && !pop;

    // NOTE: the storage array has no reset; the head is forced to zero while empty
    // so no uninitialised entry can ever reach the outputs.
    assign rdata_o = valid_o ? mem_q[rd_ptr_q[AW-1:0]] : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/i2s_rx_mon.sv
// Oversampling Philips-format I2S receiver that queues {left,right} frames.
// Optional per-channel peak meters are built when I2S_RX_PEAK_EN is defined.
module i2s_rx_mon
    import i2s_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i2s_sclk_i,
    input  logic              i2s_lrck_i,
    input  logic              i2s_dat_i,
    input  logic              en_i,
    output logic              smp_valid_o,
    input  logic              smp_ready_i,
    output logic [DATA_W-1:0] smp_left_o,
    output logic [DATA_W-1:0] smp_right_o,
    output logic              ovf_o,
    input  logic              err_clr_i,
`ifdef I2S_RX_PEAK_EN
    output logic [DATA_W-1:0] peak_l_o,
    output logic [DATA_W-1:0] peak_r_o,
    input  logic              peak_clr_i,
`endif
    output logic              frm_err_o
);

    localparam int               CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

    logic [SYNC_STAGES-1:0] sclk_sync_q, lrck_sync_q, dat_sync_q;
    logic sclk_s, lrck_s, dat_s;
    logic sclk_prev_q, lrck_prev_q, lrck_seen_q;
    logic sclk_rise, lrck_chg;

    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d, shifted;
    logic              chan_q, chan_d;
    logic [DATA_W-1:0] hold_l_q, hold_l_d;
    logic              l_ok_q, l_ok_d;
    logic              frm_err_q, frm_err_d, ovf_q, ovf_d;
    logic              word_done, frm_err_set, push, fifo_drop;
    logic [DATA_W-1:0] word_data;
    logic [2*DATA_W-1:0] head;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign lrck_s    = lrck_sync_q[SYNC_STAGES-1];
    assign dat_s     = dat_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s && !sclk_prev_q;
    assign lrck_chg  = sclk_rise && lrck_seen_q && (lrck_s != lrck_prev_q);
    assign shifted   = {shift_q[DATA_W-2:0], dat_s};

    // NOTE: clocked state uses non-blocking assignments so every flop samples the
    // pre-edge value of its neighbour; blocking here would collapse the synchroniser.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_sync_q <= '0;
            lrck_sync_q <= '0;
            dat_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
            lrck_prev_q <= 1'b0;
            lrck_seen_q <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i2s_sclk_i};
            lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], i2s_lrck_i};
            dat_sync_q  <= {dat_sync_q[SYNC_STAGES-2:0], i2s_dat_i};
            sclk_prev_q <= sclk_s;
            if (sclk_rise) begin
                lrck_prev_q <= lrck_s;
                lrck_seen_q <= 1'b1;
            end
        end
    end

    // NOTE: every variable gets a default before any branch, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        chan_d      = chan_q;
        word_done   = 1'b0;
        word_data   = shifted;
        frm_err_set = 1'b0;
        if (!en_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (sclk_rise) begin
            case (state_q)
                ST_IDLE: begin
                    if (lrck_chg && lrck_s == LRCK_LEFT) begin
                        state_d = ST_SHIFT;
                        cnt_d   = '0;
                        chan_d  = LRCK_LEFT;
                    end
                end
                ST_SHIFT: begin
                    if (lrck_chg) begin
                        // Word select moves one bit early: this rise carries the LSB.
                        if (cnt_q == CNT_LAST) word_done   = 1'b1;
                        else                   frm_err_set = 1'b1;
                        cnt_d  = '0;
                        chan_d = lrck_s;
                    end else begin
                        shift_d = shifted;
                        if (cnt_q == CNT_LAST) begin
                            cnt_d     = CNT_FULL;
                            word_done = 1'b1;
                            state_d   = ST_PAD;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_PAD: begin
                    if (lrck_chg) begin
                        cnt_d   = '0;
                        chan_d  = lrck_s;
                        state_d = ST_SHIFT;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        hold_l_d = hold_l_q;
        l_ok_d   = l_ok_q;
        push     = 1'b0;
        if (!en_i) begin
            l_ok_d = 1'b0;
        end else if (word_done) begin
            if (chan_q == LRCK_LEFT) begin
                hold_l_d = word_data;
                l_ok_d   = 1'b1;
            end else if (l_ok_q) begin
                push   = 1'b1;
                l_ok_d = 1'b0;
            end
        end
        frm_err_d = frm_err_set ? 1'b1 : (err_clr_i ? 1'b0 : frm_err_q);
        ovf_d     = fifo_drop   ? 1'b1 : (err_clr_i ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            chan_q    <= LRCK_LEFT;
            hold_l_q  <= '0;
            l_ok_q    <= 1'b0;
            frm_err_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            chan_q    <= chan_d;
            hold_l_q  <= hold_l_d;
            l_ok_q    <= l_ok_d;
            frm_err_q <= frm_err_d;
            ovf_q     <= ovf_d;
        end
    end

    i2s_rx_fifo #(
        .WIDTH (2 * DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .wdata_i ({hold_l_q, word_data}),
        .ready_i (smp_ready_i),
        .valid_o (smp_valid_o),
        .rdata_o (head),
        .drop_o  (fifo_drop)
    );

    assign smp_left_o  = head[2*DATA_W-1:DATA_W];
    assign smp_right_o = head[DATA_W-1:0];
    assign ovf_o       = ovf_q;
    assign frm_err_o   = frm_err_q;

`ifdef I2S_RX_PEAK_EN
    logic [DATA_W-1:0] peak_l_q, peak_l_d, peak_r_q, peak_r_d;
    logic [DATA_W-1:0] abs_l, abs_r;

    // The most negative code has no positive twin, so it clamps to max positive.
    function automatic logic [DATA_W-1:0] abs_sat(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] neg;
        neg = ~v + DATA_W'(1);
        if (!v[DATA_W-1])    return v;
        else if (neg[DATA_W-1]) return {1'b0, {(DATA_W-1){1'b1}}};
        else                 return neg;
    endfunction

    assign abs_l = abs_sat(hold_l_q);
    assign abs_r = abs_sat(word_data);

    always_comb begin
        peak_l_d = peak_l_q;
        peak_r_d = peak_r_q;
        if (peak_clr_i) begin
            peak_l_d = '0;
            peak_r_d = '0;
        end else if (push && !fifo_drop) begin
            if (abs_l > peak_l_q) peak_l_d = abs_l;
            if (abs_r > peak_r_q) peak_r_d = abs_r;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            peak_l_q <= '0;
            peak_r_q <= '0;
        end else begin
            peak_l_q <= peak_l_d;
            peak_r_q <= peak_r_d;
        end
    end

    assign peak_l_o = peak_l_q;
    assign peak_r_o = peak_r_q;
`endif

endmodule

// File: tb/tb_i2s_rx_mon.sv
// Directed bench for i2s_rx_mon: a bit-level I2S source feeds the DUT, expected
// frames go into a queue, and a monitor compares every popped FIFO head.
`timescale 1ns/1ps
module tb_i2s_rx_mon;

    localparam int DATA_W = 16;

    logic clk = 1'b0;
    logic rst_i, en_i, smp_ready_i, err_clr_i;
    logic i2s_sclk, i2s_lrck, i2s_dat;
    logic smp_valid_o, ovf_o, frm_err_o;
    logic [DATA_W-1:0] smp_left_o, smp_right_o;
`ifdef I2S_RX_PEAK_EN
    logic [DATA_W-1:0] peak_l_o, peak_r_o;
    logic peak_clr_i;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_head;
    logic carry;

    always #5 clk = ~clk;

    i2s_rx_mon dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .i2s_sclk_i  (i2s_sclk),
        .i2s_lrck_i  (i2s_lrck),
        .i2s_dat_i   (i2s_dat),
        .en_i        (en_i),
        .smp_valid_o (smp_valid_o),
        .smp_ready_i (smp_ready_i),
        .smp_left_o  (smp_left_o),
        .smp_right_o (smp_right_o),
        .ovf_o       (ovf_o),
        .err_clr_i   (err_clr_i),
`ifdef I2S_RX_PEAK_EN
        .peak_l_o    (peak_l_o),
        .peak_r_o    (peak_r_o),
        .peak_clr_i  (peak_clr_i),
`endif
        .frm_err_o   (frm_err_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compares each head the sink accepts.
    always @(negedge clk) begin
        if (!rst_i && smp_valid_o && smp_ready_i) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_frame: got %h_%h, expected none", smp_left_o, smp_right_o);
            end else begin
                exp_head = exp_q.pop_front();
                if ({smp_left_o, smp_right_o} !== exp_head) begin
                    n_errors++;
                    $display("FAIL frame: got %h_%h, expected %h", smp_left_o, smp_right_o, exp_head);
                end
            end
        end
    end

    // One bit period = 8 clk; data and word select change while sclk is low.
    task automatic send_bit(input logic ws, input logic b);
        i2s_lrck = ws;
        i2s_dat  = b;
        #40 i2s_sclk = 1'b1;
        #40 i2s_sclk = 1'b0;
    endtask

    // Philips slot: first bit is the previous slot's last bit, MSB follows.
    task automatic send_slot(input logic ws, input logic [15:0] w, input int nbits);
        logic [31:0] sv;
        sv = {w, 16'h0000};
        send_bit(ws, carry);
        for (int i = 0; i < nbits - 1; i++) send_bit(ws, sv[31-i]);
        carry = sv[31-(nbits-1)];
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int nbits,
                              input bit expect_push);
        if (expect_push) exp_q.push_back({l, r});
        send_slot(1'b0, l, nbits);
        send_slot(1'b1, r, nbits);
    endtask

    task automatic start_test();
        @(posedge clk); #1;
        en_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 en_i = 1'b1;
        carry = 1'b0;
        send_slot(1'b1, 16'h0000, 4);
    endtask

    task automatic end_test();
        send_bit(1'b0, carry);
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check(name, exp_q.size(), 0);
        check({name, "_empty"}, smp_valid_o, 1'b0);
    endtask

    task automatic pulse_err_clr();
        @(posedge clk); #1 err_clr_i = 1'b1;
        @(posedge clk); #1 err_clr_i = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; en_i = 1'b1; smp_ready_i = 1'b1; err_clr_i = 1'b0;
        i2s_sclk = 1'b0; i2s_lrck = 1'b0; i2s_dat = 1'b0; carry = 1'b0;
`ifdef I2S_RX_PEAK_EN
        peak_clr_i = 1'b0;
`endif
        repeat (5) @(posedge clk);
        #1;
        check("rst_valid", smp_valid_o, 1'b0);
        check("rst_left",  smp_left_o,  '0);
        check("rst_right", smp_right_o, '0);
        check("rst_ovf",   ovf_o,       1'b0);
        check("rst_frm",   frm_err_o,   1'b0);
        rst_i = 1'b0;

        // 1: 16-bit slots, extreme codes.
        start_test();
        send_frame(16'h8001, 16'h7FFE, 16, 1'b1);
        end_test();
        drain("t1_drain");
        check("t1_ovf", ovf_o, 1'b0);
        check("t1_frm", frm_err_o, 1'b0);

        // 2: 32-bit slots, sample left-justified in the slot.
        start_test();
        send_frame(16'h1234, 16'hABCD, 32, 1'b1);
        end_test();
        drain("t2_drain");
        check("t2_frm", frm_err_o, 1'b0);

        // 3: short left slot, then a good frame.
        start_test();
        send_slot(1'b0, 16'hFFFF, 10);
        send_slot(1'b1, 16'h1111, 16);
        send_frame(16'h5A5A, 16'hC3C3, 16, 1'b1);
        end_test();
        drain("t3_drain");
        check("t3_frm_set", frm_err_o, 1'b1);
        pulse_err_clr();
        check("t3_frm_clr", frm_err_o, 1'b0);

        // 4: stalled sink, nine frames into eight entries.
        @(posedge clk); #1 smp_ready_i = 1'b0;
        start_test();
        for (int k = 1; k <= 9; k++)
            send_frame(16'h1000 + 16'(k), 16'h2000 + 16'(k), 16, k <= 8);
        end_test();
        check("t4_ovf_set", ovf_o, 1'b1);
        check("t4_valid", smp_valid_o, 1'b1);
        check("t4_held", {smp_left_o, smp_right_o}, 32'h1001_2001);
        smp_ready_i = 1'b1;
        drain("t4_drain");
        pulse_err_clr();
        check("t4_ovf_clr", ovf_o, 1'b0);

        // 5: enable dropped mid right word.
        start_test();
        send_slot(1'b0, 16'h4444, 16);
        send_slot(1'b1, 16'h5555, 8);
        en_i = 1'b0;
        repeat (20) @(posedge clk);
        #1 en_i = 1'b1;
        send_slot(1'b1, 16'hFFFF, 8);
        send_frame(16'h0F0F, 16'hF0F0, 16, 1'b1);
        end_test();
        drain("t5_drain");
        check("t5_frm", frm_err_o, 1'b0);

`ifdef I2S_RX_PEAK_EN
        // 6: peak meters with saturation of the most negative code.
        @(posedge clk); #1 peak_clr_i = 1'b1;
        @(posedge clk); #1 peak_clr_i = 1'b0;
        start_test();
        send_frame(16'h8000, 16'hFFF0, 16, 1'b1);
        end_test();
        drain("t6_drain");
        check("t6_peak_l", peak_l_o, 16'h7FFF);
        check("t6_peak_r", peak_r_o, 16'h0010);
        @(posedge clk); #1 peak_clr_i = 1'b1;
        @(posedge clk); #1 peak_clr_i = 1'b0;
        check("t6_clr_l", peak_l_o, 16'h0000);
        check("t6_clr_r", peak_r_o, 16'h0000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
